// File: rtl/l2_pkg.sv
// Shared types and defaults for the layer-2 scan sequencer and its valid pipe.
package l2_pkg;

  localparam int CW_DEF     = 10;
  localparam int RD_LAT_DEF = 2;
  localparam int GW         = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Geometry sanity apart from the window-area limit, which depends on CW.
  function automatic logic geom_ok(
    input logic [GW-1:0] ht_sm,
    input logic [GW-1:0] wt_sm,
    input logic [GW-1:0] ht_lg,
    input logic [GW-1:0] wt_lg,
    input logic [GW-1:0] factor
  );
    return (ht_sm != '0) && (wt_sm != '0) && (factor != '0) &&
           (ht_sm <= ht_lg) && (wt_sm <= wt_lg);
  endfunction

endpackage

// File: rtl/l2_valid_pipe.sv
// RD_LAT-deep {valid, win_last} shift register tracking BRAM read latency.
module l2_valid_pipe
  import l2_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic clk,
  input  logic i_flush,
  input  logic i_adv,
  input  logic i_vld,
  input  logic i_last,
  output logic o_vld,
  output logic o_last,
  output logic o_empty
);

  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_last;
  logic [RD_LAT-1:0] w_vld_in;
  logic [RD_LAT-1:0] w_last_in;

  assign w_vld_in[0]  = i_vld;
  assign w_last_in[0] = i_last;

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
      assign w_vld_in[gi]  = r_vld[gi-1];
      assign w_last_in[gi] = r_last[gi-1];
    end
  endgenerate

  // The pipe only moves together with the BRAM output register.
  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_vld  <= '0;
      r_last <= '0;
    end else if (i_adv) begin
      r_vld  <= w_vld_in;
      r_last <= w_last_in;
    end
  end

  assign o_vld   = r_vld[RD_LAT-1];
  assign o_last  = r_last[RD_LAT-1];
  assign o_empty = ~|r_vld;

endmodule

// File: rtl/l2_scan_ctrl.sv
// Sequencer for the layer-2 window address generator and the feature-map BRAM read path.
module l2_scan_ctrl
  import l2_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [8:0]    cfg_ht_sm,
  input  logic [8:0]    cfg_wt_sm,
  input  logic [8:0]    cfg_ht_lg,
  input  logic [8:0]    cfg_wt_lg,
  input  logic [8:0]    cfg_factor,
  output logic          agen_rst,
  output logic          agen_en,
  output logic [CW-1:0] count1,
  input  logic          agen_conv_done,
  output logic          mem_ce,
  output logic          out_valid,
  output logic          out_win_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          err_cfg
);

  localparam logic [2*GW-1:0] AREA_MAX = (2*GW)'(2**CW);

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_count1;
  logic [CW-1:0]   r_limit1;
  logic            r_err_cfg;
  logic            r_flush;

  logic [2*GW-1:0] w_area;
  logic            w_cfg_ok;
  logic            w_live;
  logic            w_busy_st;
  logic            w_abort;
  logic            w_adv;
  logic            w_flush;
  logic            w_pipe_vld;
  logic            w_pipe_last;
  logic            w_pipe_empty;

  assign w_area    = {9'd0, cfg_ht_sm} * {9'd0, cfg_wt_sm};
  assign w_cfg_ok  = geom_ok(cfg_ht_sm, cfg_wt_sm, cfg_ht_lg, cfg_wt_lg, cfg_factor) &&
                     (w_area <= AREA_MAX);
  assign w_live    = !rst;
  assign w_busy_st = (r_state == ST_INIT) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_abort   = abort && w_busy_st;
  // A beat held at the output freezes the whole read path, generator included.
  assign w_adv     = !(w_pipe_vld && !out_ready);
  assign w_flush   = rst || w_abort || (r_state == ST_INIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    agen_rst     = rst || r_flush;
    agen_en      = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start && w_cfg_ok) w_state_next = ST_INIT;
      end
      ST_INIT: begin
        agen_rst     = 1'b1;
        w_state_next = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        agen_en = w_live && w_adv && !agen_conv_done;
        if (abort)               w_state_next = ST_IDLE;
        else if (agen_conv_done) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)             w_state_next = ST_IDLE;
        else if (w_pipe_empty) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = w_live;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count1  <= '0;
      r_limit1  <= '0;
      r_err_cfg <= 1'b0;
      r_flush   <= 1'b1;
    end else begin
      r_err_cfg <= (r_state == ST_IDLE) && start && !w_cfg_ok;
      r_flush   <= w_abort;
      if ((r_state == ST_IDLE) && start && w_cfg_ok) begin
        r_limit1 <= CW'(w_area - 1'b1);
      end
      if ((r_state == ST_INIT) || w_abort) begin
        r_count1 <= '0;
      end else if (agen_en) begin
        r_count1 <= (r_count1 == r_limit1) ? '0 : r_count1 + 1'b1;
      end
    end
  end

  l2_valid_pipe #(
    .RD_LAT(RD_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .i_flush(w_flush),
    .i_adv  (w_adv),
    .i_vld  (agen_en),
    .i_last (agen_en && (r_count1 == r_limit1)),
    .o_vld  (w_pipe_vld),
    .o_last (w_pipe_last),
    .o_empty(w_pipe_empty)
  );

  assign out_valid    = w_live && w_pipe_vld;
  assign out_win_last = w_live && w_pipe_vld && w_pipe_last;
  assign mem_ce       = w_live && w_adv;
  assign busy         = w_live && w_busy_st;
  assign err_cfg      = w_live && r_err_cfg;
  assign count1       = w_live ? r_count1 : '0;

endmodule

// File: tb/tb_l2_scan_ctrl.sv
// Directed bench for l2_scan_ctrl with a behavioural address generator and a beat scoreboard.
module tb_l2_scan_ctrl;

  localparam int RD_LAT = 2;
  localparam int CW     = 10;
  localparam int TOTAL  = 64;

  logic          clk = 1'b0;
  logic          rst, start, abort, out_ready;
  logic [8:0]    cfg_ht_sm, cfg_wt_sm, cfg_ht_lg, cfg_wt_lg, cfg_factor;
  logic          agen_rst, agen_en, agen_conv_done, mem_ce;
  logic          out_valid, out_win_last, busy, done, err_cfg;
  logic [CW-1:0] count1;

  always #5 clk = ~clk;

  l2_scan_ctrl #(.RD_LAT(RD_LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_ht_sm(cfg_ht_sm), .cfg_wt_sm(cfg_wt_sm), .cfg_ht_lg(cfg_ht_lg),
    .cfg_wt_lg(cfg_wt_lg), .cfg_factor(cfg_factor),
    .agen_rst(agen_rst), .agen_en(agen_en), .count1(count1),
    .agen_conv_done(agen_conv_done), .mem_ce(mem_ce),
    .out_valid(out_valid), .out_win_last(out_win_last), .out_ready(out_ready),
    .busy(busy), .done(done), .err_cfg(err_cfg)
  );

  // Generator model: finishes after TOTAL advances since its last reset.
  int g_cnt = 0;
  always @(posedge clk) begin
    if (agen_rst)                     g_cnt <= 0;
    else if (agen_en && g_cnt < TOTAL) g_cnt <= g_cnt + 1;
  end
  assign agen_conv_done = (g_cnt == TOTAL);

  int n_vec = 0, n_err = 0;
  int cyc = 0, beats = 0, lasts = 0, dones = 0;
  int exp_cnt = 0, m_limit = 3, first_valid = 0;
  bit seen_valid = 0, prev_stall = 0, prev_last = 0, exp_last;
  bit q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: check the combinational view at negedge, return 1ns after posedge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_last", out_win_last, prev_last);
    end
    if (out_valid && !out_ready) begin
      chk("stall_agen_en", agen_en, 0);
      chk("stall_mem_ce", mem_ce, 0);
    end else if (!rst) begin
      chk("mem_ce_adv", mem_ce, 1);
    end
    if (out_valid && !seen_valid) begin
      seen_valid  = 1;
      first_valid = cyc;
    end
    if (out_valid && out_ready) begin
      chk("sb_nonempty", q.size() > 0, 1);
      if (q.size() > 0) begin
        exp_last = q.pop_front();
        chk("win_last", out_win_last, exp_last);
      end
      beats++;
      if (out_win_last) lasts++;
    end
    if (agen_en) begin
      chk("count1", count1, exp_cnt);
      q.push_back(exp_cnt == m_limit);
      exp_cnt = (exp_cnt == m_limit) ? 0 : exp_cnt + 1;
    end
    if (done) begin
      dones++;
      chk("done_busy", busy, 0);
      chk("done_beats", beats, TOTAL);
    end
    prev_stall = out_valid && !out_ready && !abort && !rst;
    prev_last  = out_win_last;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int hs, input int ws, input int hl, input int wl, input int f);
    cfg_ht_sm  = 9'(hs);
    cfg_wt_sm  = 9'(ws);
    cfg_ht_lg  = 9'(hl);
    cfg_wt_lg  = 9'(wl);
    cfg_factor = 9'(f);
  endtask

  task automatic scan(input bit bp, input int abort_at, input int rst_at, input int start_at,
                      output bit finished, output int start_cyc);
    bit sfired = 0;
    bit was_abort;
    finished = 0;
    set_cfg(2, 2, 6, 6, 2);
    m_limit = 3; exp_cnt = 0; q.delete();
    beats = 0; lasts = 0; dones = 0; seen_valid = 0;
    out_ready = 1; start = 1;
    step();
    start_cyc = cyc;
    start = 0;
    chk("init_busy", busy, 1);
    chk("init_agen_rst", agen_rst, 1);
    chk("init_count1", count1, 0);
    for (int i = 0; i < 3000; i++) begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      abort = (abort_at >= 0) && (beats >= abort_at);
      rst   = (rst_at >= 0) && (beats >= rst_at);
      start = rst || (start_at >= 0 && !sfired && beats >= start_at);
      if (start && !rst) begin
        sfired = 1;
        set_cfg(1, 1, 6, 6, 2);
      end
      step();
      start = 0;
      set_cfg(2, 2, 6, 6, 2);
      if (abort || rst) begin
        was_abort = abort;
        abort = 0; rst = 0; out_ready = 1;
        #1;
        q.delete(); exp_cnt = 0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_agen_rst", agen_rst, 1);
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        if (!was_abort) begin
          chk("rst_err_cfg", err_cfg, 0);
          chk("rst_agen_en", agen_en, 0);
          chk("rst_count1", count1, 0);
        end
        repeat (20) step();
        chk("flush_no_done", dones, 0);
        chk("flush_idle_busy", busy, 0);
        return;
      end
      if (dones > 0) begin
        finished = 1;
        break;
      end
    end
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  task automatic cfg_err(input string tag, input int hs, input int ws, input int hl, input int wl, input int f);
    set_cfg(hs, ws, hl, wl, f);
    start = 1;
    step();
    start = 0;
    set_cfg(2, 2, 6, 6, 2);
    #1;
    chk({tag, "_err"}, err_cfg, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_agen_rst"}, agen_rst, 0);
    step();
    chk({tag, "_err_pulse"}, err_cfg, 0);
    chk({tag, "_busy2"}, busy, 0);
  endtask

  initial begin
    bit fin;
    int sc;
    rst = 1; start = 0; abort = 0; out_ready = 1;
    set_cfg(2, 2, 6, 6, 2);
    repeat (3) step();
    chk("rst_agen_rst", agen_rst, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_ce", mem_ce, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_cfg, 0);
    chk("rst_agen_en", agen_en, 0);
    chk("rst_count1", count1, 0);
    rst = 0;
    repeat (2) step();

    scan(0, -1, -1, -1, fin, sc);
    chk("basic_finished", fin, 1);
    chk("basic_beats", beats, TOTAL);
    chk("basic_lasts", lasts, TOTAL / 4);
    chk("basic_dones", dones, 1);
    chk("basic_first_lat", first_valid - sc, RD_LAT + 2);

    scan(1, -1, -1, -1, fin, sc);
    chk("bp_finished", fin, 1);
    chk("bp_beats", beats, TOTAL);
    chk("bp_lasts", lasts, TOTAL / 4);

    cfg_err("cfg_wt0", 2, 0, 6, 6, 2);
    cfg_err("cfg_ht_gt", 7, 2, 6, 6, 2);
    cfg_err("cfg_area", 33, 33, 40, 40, 2);

    scan(0, 20, -1, -1, fin, sc);
    scan(0, -1, -1, -1, fin, sc);
    chk("post_abort_finished", fin, 1);
    chk("post_abort_beats", beats, TOTAL);

    scan(0, -1, 10, -1, fin, sc);
    scan(0, -1, -1, 30, fin, sc);
    chk("busy_start_finished", fin, 1);
    chk("busy_start_beats", beats, TOTAL);
    chk("busy_start_lasts", lasts, TOTAL / 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l2_scan_ctrl.md
Name: l2_scan_ctrl

Overview:
- Sequencer for the layer-2 window address generator (address_l2) and the feature-map BRAM it addresses.
- Accepts a start command with geometry, then resets the generator and drives its enable and count1 window counter.
- Gates the BRAM read-register clock enable and tags read data with valid and window-last through a latency-matched pipeline, with downstream backpressure.
- Reports busy/done/config error; supports abort.

Parameters:
RD_LAT, 2, BRAM read latency in cycles from address to data (1..4)
CW, 10, width of count1 and window limit

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle command; sampled only in IDLE
abort  in  1  cancel current scan; sampled in INIT/RUN/DRAIN
cfg_ht_sm, cfg_wt_sm, cfg_ht_lg, cfg_wt_lg, cfg_factor  in  9 each  geometry, latched on accepted start
agen_rst  out  1  synchronous reset to address generator
agen_en  out  1  address generator advance
count1  out  CW  position inside current small window
agen_conv_done  in  1  generator's conv_done
mem_ce  out  1  BRAM read-register clock enable
out_valid  out  1  BRAM data valid this cycle
out_win_last  out  1  qualifies out_valid: last pixel of a window
out_ready  in  1  downstream accepts
busy  out  1  high in INIT/RUN/DRAIN
done  out  1  one-cycle pulse at scan completion
err_cfg  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset values: agen_rst=1 during rst; all other outputs 0; state IDLE; valid pipe cleared.
- States: IDLE, INIT, RUN, DRAIN, DONE.
- Start check (IDLE, start=1): reject if any of ht_sm, wt_sm, factor is 0; ht_sm>ht_lg; wt_sm>wt_lg; or ht_sm*wt_sm>2^CW.
  - Reject: err_cfg=1 next cycle, remain IDLE, config not latched.
  - Accept: latch config, limit1 = ht_sm*wt_sm-1 (CW bits), go INIT.
- INIT (1 cycle): agen_rst=1, count1<=0, valid pipe cleared; next state RUN.
- adv = !(out_valid && !out_ready). mem_ce = adv in every state. The valid/win_last pipe (RD_LAT stages) shifts only when adv.
- RUN: agen_en = adv && !agen_conv_done (combinational gate).
  - Each agen_en cycle pushes valid=1 with tag (count1==limit1) into pipe stage 0; count1 increments, wrapping to 0 after limit1.
  - Cycles without agen_en push a bubble when adv.
  - agen_conv_done=1 -> DRAIN; no further issue.
- DRAIN: agen_en=0; bubbles shift in while adv. When pipe empty and out_valid=0 -> DONE.
- DONE: done=1 for one cycle -> IDLE. busy=0 in DONE and IDLE.
- Abort in INIT/RUN/DRAIN: next cycle agen_rst=1, pipe flushed, out_valid=0, state IDLE, no done pulse. Abort has priority over agen_conv_done in the same cycle.
- out_valid/out_win_last hold stable while out_ready=0 (AXI-style); no beat is lost or duplicated.
- start while busy: ignored. rst mid-scan: immediate return to reset values; generator held reset.
- Issue-to-data latency: exactly RD_LAT advancing cycles.

Decomposition:
- Shared package l2_pkg: state enum (IDLE, INIT, RUN, DRAIN, DONE), CW, RD_LAT default, geometry width 9.
- One sub-module: l2_valid_pipe (RD_LAT-deep shift register of {valid, win_last} with advance enable and flush).

Test Plan:
- Basic scan: ht_sm=wt_sm=2, factor=2, ht_lg=wt_lg=6, out_ready=1 -> exactly 64 out_valid beats with 16 out_win_last; count1 cycles 0..3; first out_valid RD_LAT+2 cycles after start; one done pulse after last beat; busy falls with done.
- Backpressure: same config, out_ready toggled 1-0-0-1 pseudo-randomly -> still 64 beats; out_valid/out_win_last stable during stalls; agen_en=0 and mem_ce=0 whenever out_valid && !out_ready.
- Config error: cfg_wt_sm=0, then separately ht_sm=7 with ht_lg=6 -> err_cfg single pulse each, busy stays 0, no agen_rst pulse.
- Abort: abort asserted at beat 20 of the basic scan -> out_valid=0 next cycle, agen_rst pulse, no done; a following start completes a full 64-beat scan.
- Reset mid-run: rst asserted in RUN for 1 cycle -> all outputs at reset values next cycle; start ignored while rst=1.
- Start while busy: start pulsed during RUN -> ignored, beat count still 64, config unchanged.
